uart_top: RTL and testbench

//   Full-duplex UART: one transmitter and one receiver sharing a clock and a baud divider.

---
 rtl/uart_top.sv | 184 ++++++++++++++++++
 tb/tb_uart_top.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_top.sv
// uart_top: full-duplex UART, frames of start(0) + DATABITS LSB-first + even parity + stop(1)
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   tx_start     one-cycle transmit request, accepted only while TX is idle
//   tx_data      word to transmit, captured when tx_start is accepted
//   rx_line      serial input (asynchronous, idle high)
//   tx_line      serial output (idle high)
//   rx_data      last validly framed received word
//   rx_done      one-cycle pulse when rx_data/parity_error update
//   parity_error parity result of the last valid frame
module uart_top #(
    parameter int DATABITS = 8,
    parameter int BAUD_DIV = 2604
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tx_start,
    input  logic [DATABITS-1:0] tx_data,
    input  logic                rx_line,
    output logic                tx_line,
    output logic [DATABITS-1:0] rx_data,
    output logic                rx_done,
    output logic                parity_error
);
    localparam int CW = $clog2(BAUD_DIV);
    localparam int BW = $clog2(DATABITS);
    localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2);
    localparam logic [BW-1:0] LAST = BW'(DATABITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t              tx_state, tx_state_n;
    logic [CW-1:0]       tx_cnt, tx_cnt_n;
    logic [BW-1:0]       tx_bit, tx_bit_n;
    logic [DATABITS-1:0] tx_sh, tx_sh_n;
    logic                tx_par, tx_par_n, tx_line_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_sh    <= '0;
            tx_par   <= 1'b0;
            tx_line  <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_sh    <= tx_sh_n;
            tx_par   <= tx_par_n;
            tx_line  <= tx_line_n;
        end
    end

    // tx_line is registered from the next-state values so it changes exactly on state edges
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_bit_n   = tx_bit;
        tx_sh_n    = tx_sh;
        tx_par_n   = tx_par;
        if (tx_state == IDLE) begin
            if (tx_start) begin
                tx_state_n = START;
                tx_cnt_n   = FULL;
                tx_sh_n    = tx_data;
                tx_par_n   = ^tx_data;
            end
        end else if (tx_cnt != '0) begin
            tx_cnt_n = tx_cnt - CW'(1);
        end else begin
            tx_cnt_n = FULL;
            case (tx_state)
                START: begin
                    tx_state_n = DATA;
                    tx_bit_n   = '0;
                end
                DATA: begin
                    if (tx_bit == LAST) begin
                        tx_state_n = PARITY;
                    end else begin
                        tx_bit_n = tx_bit + BW'(1);
                        tx_sh_n  = tx_sh >> 1;
                    end
                end
                PARITY:  tx_state_n = STOP;
                default: tx_state_n = IDLE;
            endcase
        end
        tx_line_n = (tx_state_n == START)  ? 1'b0 :
                    (tx_state_n == DATA)   ? tx_sh_n[0] :
                    (tx_state_n == PARITY) ? tx_par_n : 1'b1;
    end

    logic                rx_s1, rx_s2;
    state_t              rx_state, rx_state_n;
    logic [CW-1:0]       rx_cnt, rx_cnt_n;
    logic [BW-1:0]       rx_bit, rx_bit_n;
    logic [DATABITS-1:0] rx_sh, rx_sh_n, rx_data_n;
    logic                rx_perr, rx_perr_n, perr_n, rx_done_n;
    // armed: line has been seen high in IDLE, so a low level is a genuine 1->0 edge
    logic                armed, armed_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_s1        <= 1'b1;
            rx_s2        <= 1'b1;
            rx_state     <= IDLE;
            rx_cnt       <= '0;
            rx_bit       <= '0;
            rx_sh        <= '0;
            rx_perr      <= 1'b0;
            armed        <= 1'b0;
            rx_data      <= '0;
            rx_done      <= 1'b0;
            parity_error <= 1'b0;
        end else begin
            rx_s1        <= rx_line;
            rx_s2        <= rx_s1;
            rx_state     <= rx_state_n;
            rx_cnt       <= rx_cnt_n;
            rx_bit       <= rx_bit_n;
            rx_sh        <= rx_sh_n;
            rx_perr      <= rx_perr_n;
            armed        <= armed_n;
            rx_data      <= rx_data_n;
            rx_done      <= rx_done_n;
            parity_error <= perr_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_bit_n   = rx_bit;
        rx_sh_n    = rx_sh;
        rx_perr_n  = rx_perr;
        armed_n    = armed;
        rx_data_n  = rx_data;
        perr_n     = parity_error;
        rx_done_n  = 1'b0;
        if (rx_state == IDLE) begin
            if (rx_s2) begin
                armed_n = 1'b1;
            end else if (armed) begin
                rx_state_n = START;
                rx_cnt_n   = HALF;
            end
        end else if (rx_cnt != '0) begin
            rx_cnt_n = rx_cnt - CW'(1);
        end else begin
            rx_cnt_n = FULL;
            case (rx_state)
                START: begin
                    rx_state_n = rx_s2 ? IDLE : DATA;
                    rx_bit_n   = '0;
                end
                DATA: begin
                    rx_sh_n = {rx_s2, rx_sh[DATABITS-1:1]};
                    if (rx_bit == LAST)
                        rx_state_n = PARITY;
                    else
                        rx_bit_n = rx_bit + BW'(1);
                end
                PARITY: begin
                    rx_perr_n  = ^rx_sh ^ rx_s2;
                    rx_state_n = STOP;
                end
                default: begin
                    rx_state_n = IDLE;
                    if (rx_s2) begin
                        rx_data_n = rx_sh;
                        perr_n    = rx_perr;
                        rx_done_n = 1'b1;
                    end else begin
                        armed_n = 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_top.sv
// tb_uart_top: self-checking bench for uart_top (loopback, directly driven frames, reset abort)
module tb_uart_top;
    localparam int D = 8;
    localparam int B = 16;
    localparam int F = (D + 3) * B;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         tx_start = 1'b0;
    logic [D-1:0] tx_data = '0;
    logic         rx_drv = 1'b1;
    logic         loop = 1'b1;
    logic         rx_line, tx_line, rx_done, parity_error;
    logic [D-1:0] rx_data;

    int checks = 0;
    int errors = 0;
    logic [8:0]   rxq[$];
    logic [D-1:0] last_d = '0;
    logic         last_pe = 1'b0;

    assign rx_line = loop ? tx_line : rx_drv;

    uart_top #(.DATABITS(D), .BAUD_DIV(B)) dut (
        .clk(clk), .reset(reset), .tx_start(tx_start), .tx_data(tx_data),
        .rx_line(rx_line), .tx_line(tx_line), .rx_data(rx_data),
        .rx_done(rx_done), .parity_error(parity_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rx_done) rxq.push_back({parity_error, rx_data});

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_rx(input logic [D-1:0] d, input logic pe);
        logic [8:0] r;
        chk("rx_count", rxq.size(), 1);
        if (rxq.size() > 0) begin
            r = rxq.pop_front();
            chk("rx_data", int'(r[D-1:0]), int'(d));
            chk("rx_perr", int'(r[8]), int'(pe));
        end
        rxq.delete();
        last_d = d;
        last_pe = pe;
    endtask

    task automatic expect_none();
        chk("rx_none", rxq.size(), 0);
        rxq.delete();
        chk("rx_hold", int'(rx_data), int'(last_d));
        chk("perr_hold", int'(parity_error), int'(last_pe));
    endtask

    // Sends d and checks the serial waveform at every mid-bit; a second tx_start
    // carrying ~d is pulsed at cycle 'inject' of the frame (negative = none).
    task automatic tx_frame(input logic [D-1:0] d, input int inject);
        int ebit[D+3];
        ebit[0] = 0;
        for (int i = 0; i < D; i++) ebit[i+1] = int'(d[i]);
        ebit[D+1] = $countones(d) % 2;
        ebit[D+2] = 1;
        chk("tx_idle", int'(tx_line), 1);
        tx_data = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        chk("tx_first", int'(tx_line), 0);
        for (int n = 0; n < F; n++) begin
            if (n == inject) begin
                tx_data = ~d;
                tx_start = 1'b1;
            end
            if (n == inject + 1) tx_start = 1'b0;
            if (n % B == B / 2) chk($sformatf("tx_bit%0d_%0h", n / B, d), int'(tx_line), ebit[n / B]);
            @(negedge clk);
        end
    endtask

    task automatic rx_frame(input logic [D-1:0] d, input logic p, input logic s);
        logic [D+2:0] f;
        f = {s, p, d, 1'b0};
        for (int k = 0; k < D + 3; k++) begin
            rx_drv = f[k];
            repeat (B) @(negedge clk);
        end
        rx_drv = 1'b1;
        repeat (2 * B) @(negedge clk);
    endtask

    typedef struct {
        logic [D-1:0] data;
        logic         par;
        logic         stop;
        logic         exp_done;
        logic [D-1:0] exp_data;
        logic         exp_perr;
    } rxvec_t;

    initial begin
        rxvec_t tbl[7];
        logic [D-1:0] r8;
        logic [8:0] r;
        logic bad, stp;
        int zeros;
        tbl[0] = '{8'h3C, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b1};
        tbl[1] = '{8'h3C, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0};
        tbl[2] = '{8'h5A, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0};
        tbl[3] = '{8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b1};
        tbl[4] = '{8'h80, 1'b1, 1'b1, 1'b1, 8'h80, 1'b0};
        tbl[5] = '{8'h12, 1'b1, 1'b0, 1'b0, 8'h80, 1'b0};
        tbl[6] = '{8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1};

        repeat (3) @(negedge clk);
        chk("rst_tx_line", int'(tx_line), 1);
        chk("rst_rx_data", int'(rx_data), 0);
        chk("rst_rx_done", int'(rx_done), 0);
        chk("rst_perr", int'(parity_error), 0);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        tx_frame(8'h55, -1);
        repeat (B) @(negedge clk);
        expect_rx(8'h55, 1'b0);

        tx_frame(8'hA7, -1);
        tx_frame(8'h01, -1);
        repeat (B) @(negedge clk);
        chk("b2b_count", rxq.size(), 2);
        if (rxq.size() == 2) begin
            r = rxq.pop_front();
            chk("b2b_data0", int'(r[D-1:0]), 'hA7);
            chk("b2b_perr0", int'(r[8]), 0);
            r = rxq.pop_front();
            chk("b2b_data1", int'(r[D-1:0]), 'h01);
            chk("b2b_perr1", int'(r[8]), 0);
        end
        rxq.delete();
        last_d = 8'h01;
        last_pe = 1'b0;

        tx_frame(8'h55, 3 * B + 5);
        zeros = 0;
        for (int n = 0; n < 3 * B; n++) begin
            if (tx_line == 1'b0) zeros++;
            @(negedge clk);
        end
        chk("no_second_frame", zeros, 0);
        expect_rx(8'h55, 1'b0);

        for (int i = 0; i < 6; i++) begin
            r8 = D'($urandom);
            tx_frame(r8, -1);
            repeat (B) @(negedge clk);
            expect_rx(r8, 1'b0);
        end

        loop = 1'b0;
        for (int i = 0; i < 7; i++) begin
            rx_frame(tbl[i].data, tbl[i].par, tbl[i].stop);
            if (tbl[i].exp_done) begin
                expect_rx(tbl[i].exp_data, tbl[i].exp_perr);
            end else begin
                chk("tbl_none", rxq.size(), 0);
                rxq.delete();
            end
            chk($sformatf("tbl%0d_rx_data", i), int'(rx_data), int'(tbl[i].exp_data));
            chk($sformatf("tbl%0d_perr", i), int'(parity_error), int'(tbl[i].exp_perr));
        end

        rx_drv = 1'b0;
        repeat (B / 4) @(negedge clk);
        rx_drv = 1'b1;
        repeat (2 * B) @(negedge clk);
        expect_none();

        for (int i = 0; i < 8; i++) begin
            r8 = D'($urandom);
            bad = 1'($urandom_range(1));
            stp = ($urandom_range(3) != 0);
            rx_frame(r8, 1'(($countones(r8) + int'(bad)) % 2), stp);
            if (stp) expect_rx(r8, bad);
            else expect_none();
        end

        loop = 1'b1;
        tx_data = 8'h55;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (5 * B) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_tx_line", int'(tx_line), 1);
        chk("abort_rx_done", int'(rx_done), 0);
        chk("abort_rx_data", int'(rx_data), 0);
        chk("abort_perr", int'(parity_error), 0);
        rxq.delete();
        last_d = '0;
        last_pe = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2 * B) @(negedge clk);
        expect_none();
        tx_frame(8'h55, -1);
        repeat (B) @(negedge clk);
        expect_rx(8'h55, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
